// File: rtl/uart_debug_loader.sv
// uart_debug_loader: host command decoder, big-endian program loader and CPU run/step gate
module uart_debug_loader #(
  parameter int          ADDR_W    = 10,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF,
  parameter logic [7:0]  CMD_LOAD  = 8'h6C,
  parameter logic [7:0]  CMD_RUN   = 8'h72,
  parameter logic [7:0]  CMD_STEP  = 8'h73,
  parameter logic [7:0]  ACK_LOAD  = 8'h4B,
  parameter logic [7:0]  ACK_HALT  = 8'h48,
  parameter logic [7:0]  ACK_STEP  = 8'h53,
  parameter logic [7:0]  ACK_ERR   = 8'h45
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_done,
  input  logic              i_tx_busy,
  output logic              o_tx_start,
  output logic [7:0]        o_tx_data,
  output logic              o_imem_we,
  output logic [ADDR_W-1:0] o_imem_addr,
  output logic [31:0]       o_imem_data,
  input  logic              i_cpu_halt,
  output logic              o_cpu_enable,
  output logic              o_loading
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LOAD  = 3'd1;
  localparam logic [2:0] WRITE = 3'd2;
  localparam logic [2:0] RUN   = 3'd3;
  localparam logic [2:0] STEP  = 3'd4;
  localparam logic [2:0] ACK   = 3'd5;
  logic [2:0]        state;
  logic [ADDR_W-1:0] ptr;
  logic [1:0]        cnt;
  logic [31:0]       word;
  logic [7:0]        ack_q;
  assign o_imem_we    = state == WRITE;
  assign o_imem_addr  = ptr;
  assign o_imem_data  = word;
  assign o_cpu_enable = state == RUN || state == STEP;
  assign o_loading    = state == LOAD || state == WRITE;
  // command FSM; a byte seen during WRITE already starts the next word so back-to-back bytes are never lost
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state      <= IDLE;
      ptr        <= '0;
      cnt        <= '0;
      word       <= '0;
      ack_q      <= '0;
      o_tx_start <= 1'b0;
      o_tx_data  <= '0;
    end else begin
      o_tx_start <= 1'b0;
      case (state)
        IDLE:
          if (i_rx_done) begin
            if (i_rx_data == CMD_LOAD) begin
              state <= LOAD;
              ptr   <= '0;
              cnt   <= '0;
            end else if (i_rx_data == CMD_RUN) state <= RUN;
            else if (i_rx_data == CMD_STEP) state <= STEP;
          end
        LOAD:
          if (i_rx_done) begin
            word  <= {word[23:0], i_rx_data};
            cnt   <= cnt + 2'd1;
            state <= cnt == 2'd3 ? WRITE : LOAD;
          end
        WRITE: begin
          if (i_rx_done) begin
            word <= {word[23:0], i_rx_data};
            cnt  <= 2'd1;
          end
          if (word == HALT_WORD) begin
            ack_q <= ACK_LOAD;
            state <= ACK;
          end else if (&ptr) begin
            ack_q <= ACK_ERR;
            state <= ACK;
          end else begin
            ptr   <= ptr + ADDR_W'(1);
            state <= LOAD;
          end
        end
        RUN:
          if (i_cpu_halt) begin
            ack_q <= ACK_HALT;
            state <= ACK;
          end
        STEP: begin
          ack_q <= ACK_STEP;
          state <= ACK;
        end
        ACK:
          if (!i_tx_busy) begin
            o_tx_start <= 1'b1;
            o_tx_data  <= ack_q;
            state      <= IDLE;
          end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_debug_loader.sv
// tb_uart_debug_loader: directed checks of load, run, step, ack back-pressure, overflow and reset
module tb_uart_debug_loader;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_done = 1'b0;
  logic        tx_busy = 1'b0;
  logic        cpu_halt = 1'b0;
  logic        a_tx_start, a_we, a_en, a_loading;
  logic [7:0]  a_tx_data;
  logic [9:0]  a_addr;
  logic [31:0] a_data;
  logic        b_tx_start, b_we, b_en, b_loading;
  logic [7:0]  b_tx_data;
  logic [1:0]  b_addr;
  logic [31:0] b_data;
  int          n_chk = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          a_txn = 0, b_txn = 0, a_enn = 0;
  logic [7:0]  a_txd = '0, b_txd = '0;
  logic [31:0] a_wa[$], a_wd[$], b_wa[$], b_wd[$];
  int          a_wc[$];
  logic [7:0]  q[$];
  int          start, na, nb, t0, e0;

  uart_debug_loader u_dut (
    .i_clk(clk), .i_reset(rst_n), .i_rx_data(rx_data), .i_rx_done(rx_done), .i_tx_busy(tx_busy),
    .o_tx_start(a_tx_start), .o_tx_data(a_tx_data), .o_imem_we(a_we), .o_imem_addr(a_addr),
    .o_imem_data(a_data), .i_cpu_halt(cpu_halt), .o_cpu_enable(a_en), .o_loading(a_loading)
  );

  uart_debug_loader #(.ADDR_W(2)) u_small (
    .i_clk(clk), .i_reset(rst_n), .i_rx_data(rx_data), .i_rx_done(rx_done), .i_tx_busy(tx_busy),
    .o_tx_start(b_tx_start), .o_tx_data(b_tx_data), .o_imem_we(b_we), .o_imem_addr(b_addr),
    .o_imem_data(b_data), .i_cpu_halt(cpu_halt), .o_cpu_enable(b_en), .o_loading(b_loading)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (a_we) begin
      a_wa.push_back(32'(a_addr));
      a_wd.push_back(a_data);
      a_wc.push_back(cyc);
    end
    if (b_we) begin
      b_wa.push_back(32'(b_addr));
      b_wd.push_back(b_data);
    end
    if (a_tx_start) begin
      a_txn++;
      a_txd = a_tx_data;
    end
    if (b_tx_start) begin
      b_txn++;
      b_txd = b_tx_data;
    end
    if (a_en) a_enn++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    q.push_back(w[31:24]);
    q.push_back(w[23:16]);
    q.push_back(w[15:8]);
    q.push_back(w[7:0]);
  endtask

  task automatic send_q();
    foreach (q[i]) begin
      rx_data = q[i];
      rx_done = 1'b1;
      @(negedge clk);
    end
    rx_done = 1'b0;
    q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_tx_start", 32'(a_tx_start), 0);
    check("rst_tx_data", 32'(a_tx_data), 0);
    check("rst_we_en_ld", {a_we, a_en, a_loading}, 0);
    check("rst_addr", 32'(a_addr), 0);
    check("rst_data", a_data, 0);
    rst_n = 1'b1;
    @(negedge clk);
    q = '{8'h41, 8'h00};
    send_q();
    repeat (5) @(negedge clk);
    check("junk_writes", a_wa.size(), 0);
    check("junk_acks", a_txn, 0);
    check("junk_loading", 32'(a_loading), 0);
    q = '{8'h6C};
    send_q();
    check("load_loading", 32'(a_loading), 1);
    push_word(32'h3C010001);
    push_word(32'h3C020001);
    push_word(32'h00221821);
    push_word(32'hFFFFFFFF);
    start = cyc;
    send_q();
    repeat (6) @(negedge clk);
    check("load_nwr", a_wa.size(), 4);
    if (a_wa.size() == 4) begin
      check("load_a0", a_wa[0], 0);
      check("load_d0", a_wd[0], 32'h3C010001);
      check("load_a1", a_wa[1], 1);
      check("load_d1", a_wd[1], 32'h3C020001);
      check("load_a2", a_wa[2], 2);
      check("load_d2", a_wd[2], 32'h00221821);
      check("load_a3", a_wa[3], 3);
      check("load_d3", a_wd[3], 32'hFFFFFFFF);
      for (int w = 0; w < 4; w++) check("load_lat", a_wc[w], start + 4 + 4 * w);
    end
    check("load_ackn", a_txn, 1);
    check("load_ack", 32'(a_txd), 32'h4B);
    check("load_done", 32'(a_loading), 0);
    check("small_nwr", b_wa.size(), 4);
    check("small_ack", 32'(b_txd), 32'h4B);
    e0 = a_enn;
    t0 = a_txn;
    q = '{8'h72};
    send_q();
    repeat (9) @(negedge clk);
    rx_data = 8'h6C;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    check("run_ignore", 32'(a_loading), 0);
    check("run_en", 32'(a_en), 1);
    repeat (9) @(negedge clk);
    cpu_halt = 1'b1;
    repeat (5) @(negedge clk);
    cpu_halt = 1'b0;
    check("run_cycles", a_enn - e0, 20);
    check("run_ackn", a_txn - t0, 1);
    check("run_ack", 32'(a_txd), 32'h48);
    check("small_run_ack", 32'(b_txd), 32'h48);
    e0 = a_enn;
    t0 = a_txn;
    tx_busy = 1'b1;
    q = '{8'h73};
    send_q();
    repeat (100) @(negedge clk);
    check("step_cycles", a_enn - e0, 1);
    check("busy_hold", a_txn - t0, 0);
    check("busy_data", 32'(a_tx_data), 32'h48);
    tx_busy = 1'b0;
    repeat (10) @(negedge clk);
    check("step_ackn", a_txn - t0, 1);
    check("step_ack", 32'(a_txd), 32'h53);
    na = a_wa.size();
    nb = b_wa.size();
    t0 = b_txn;
    q = '{8'h6C};
    push_word(32'h11223344);
    push_word(32'h556C7273);
    push_word(32'h0A0B0C0D);
    push_word(32'h12345678);
    push_word(32'h01020304);
    push_word(32'hFFFFFFFF);
    send_q();
    repeat (10) @(negedge clk);
    check("ovf_nwr", b_wa.size() - nb, 4);
    if (b_wa.size() == nb + 4) begin
      check("ovf_d1", b_wd[nb + 1], 32'h556C7273);
      check("ovf_a3", b_wa[nb + 3], 3);
      check("ovf_d3", b_wd[nb + 3], 32'h12345678);
    end
    check("ovf_ackn", b_txn - t0, 1);
    check("ovf_ack", 32'(b_txd), 32'h45);
    check("ovf_idle", {b_loading, b_en}, 0);
    check("big_nwr", a_wa.size() - na, 6);
    if (a_wa.size() == na + 6) begin
      check("big_a4", a_wa[na + 4], 4);
      check("big_d4", a_wd[na + 4], 32'h01020304);
      check("big_a5", a_wa[na + 5], 5);
    end
    check("big_ack", 32'(a_txd), 32'h4B);
    t0 = a_txn;
    q = '{8'h72};
    send_q();
    repeat (3) @(negedge clk);
    check("rrun_en", 32'(a_en), 1);
    #2 rst_n = 1'b0;
    #1 check("rrun_async", 32'(a_en), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("rrun_noack", a_txn - t0, 0);
    na = a_wa.size();
    q = '{8'h6C, 8'hAA, 8'hBB};
    send_q();
    #3 rst_n = 1'b0;
    #1 check("rmid_async", 32'(a_loading), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rmid_nowr", a_wa.size() - na, 0);
    q = '{8'h6C};
    push_word(32'hDEADBEEF);
    push_word(32'hFFFFFFFF);
    send_q();
    repeat (6) @(negedge clk);
    check("rmid_nwr", a_wa.size() - na, 2);
    if (a_wa.size() == na + 2) begin
      check("rmid_a0", a_wa[na], 0);
      check("rmid_d0", a_wd[na], 32'hDEADBEEF);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
